// File: rtl/braille_key_ctrl.sv
// rtl/braille_key_ctrl.sv - Braille key sequencer: composes 6-dot cells and issues cell/command transactions
//
// Purpose:
//   Turns debounced one-pulse button events (six dots, enter, backspace, clear)
//   into Braille cell and command transactions on a valid/ready interface.
//   Simultaneous events are arbitrated clear > back > enter > dots. A composed
//   cell is committed on enter, or automatically after TIMEOUT_CYCLES idle
//   cycles in COMPOSE.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   i_dot      one-cycle dot key pulses, bit k = dot k+1
//   i_enter    one-cycle commit pulse
//   i_back     one-cycle backspace pulse
//   i_clear    one-cycle clear pulse
//   i_ready    downstream accepts the pending transaction
//   o_valid    transaction pending
//   o_cmd      transaction type: 0 = CELL, 1 = BACK, 2 = CLEAR
//   o_data     cell pattern, 0 for non-CELL transactions
//   o_pattern  live composing pattern (LED preview)
//   o_drop     one-cycle pulse when an event arriving during SEND is discarded
module braille_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] i_dot,
    input  logic       i_enter,
    input  logic       i_back,
    input  logic       i_clear,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_cmd,
    output logic [5:0] o_data,
    output logic [5:0] o_pattern,
    output logic       o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPOSE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    localparam logic [1:0] CMD_CELL  = 2'd0;
    localparam logic [1:0] CMD_BACK  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;

    // The commit fires when the counter holds this value, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [5:0]       pattern_q, pattern_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [5:0]       data_q, data_d;
    logic             drop_q, drop_d;

    logic             any_dot;
    logic             any_evt;
    logic [5:0]       toggled;
    logic             send_en;
    logic [1:0]       send_cmd;
    logic [5:0]       send_data;

    assign any_dot = |i_dot;
    assign any_evt = any_dot | i_enter | i_back | i_clear;
    assign toggled = pattern_q ^ i_dot;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        drop_d    = 1'b0;
        send_en   = 1'b0;
        send_cmd  = CMD_CELL;
        send_data = 6'd0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_clear) begin
                    send_en  = 1'b1;
                    send_cmd = CMD_CLEAR;
                end else if (i_back) begin
                    send_en  = 1'b1;
                    send_cmd = CMD_BACK;
                end else if (i_enter) begin
                    // Enter on an empty cell commits a space.
                    send_en  = 1'b1;
                    send_cmd = CMD_CELL;
                end else if (any_dot) begin
                    pattern_d = i_dot;
                    state_d   = ST_COMPOSE;
                end
            end

            ST_COMPOSE: begin
                if (i_clear) begin
                    send_en  = 1'b1;
                    send_cmd = CMD_CLEAR;
                end else if (i_back) begin
                    pattern_d = 6'd0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (i_enter) begin
                    send_en   = 1'b1;
                    send_cmd  = CMD_CELL;
                    send_data = pattern_q;
                end else if (any_dot) begin
                    pattern_d = toggled;
                    cnt_d     = '0;
                    if (toggled == 6'd0) begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    send_en   = 1'b1;
                    send_cmd  = CMD_CELL;
                    send_data = pattern_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SEND: begin
                // Every event here is lost, including one in the transfer cycle.
                drop_d = any_evt;
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    cmd_d   = CMD_CELL;
                    data_d  = 6'd0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                pattern_d = 6'd0;
                cnt_d     = '0;
                valid_d   = 1'b0;
                cmd_d     = CMD_CELL;
                data_d    = 6'd0;
            end
        endcase

        if (send_en) begin
            valid_d   = 1'b1;
            cmd_d     = send_cmd;
            data_d    = send_data;
            pattern_d = 6'd0;
            cnt_d     = '0;
            state_d   = ST_SEND;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= 6'd0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            cmd_q     <= CMD_CELL;
            data_q    <= 6'd0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_cmd     = cmd_q;
    assign o_data    = data_q;
    assign o_pattern = pattern_q;
    assign o_drop    = drop_q;

endmodule

// File: tb/tb_braille_key_ctrl.sv
// tb/tb_braille_key_ctrl.sv - directed self-checking bench for braille_key_ctrl
module tb_braille_key_ctrl;

    logic       clk;
    logic       reset_n;
    logic [5:0] i_dot;
    logic       i_enter;
    logic       i_back;
    logic       i_clear;
    logic       i_ready;
    logic       o_valid;
    logic [1:0] o_cmd;
    logic [5:0] o_data;
    logic [5:0] o_pattern;
    logic       o_drop;

    int n_cmp = 0;
    int n_err = 0;

    braille_key_ctrl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_dot    (i_dot),
        .i_enter  (i_enter),
        .i_back   (i_back),
        .i_clear  (i_clear),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_cmd    (o_cmd),
        .o_data   (o_data),
        .o_pattern(o_pattern),
        .o_drop   (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [5:0] dot, input logic ent, input logic bck, input logic clr);
        i_dot   = dot;
        i_enter = ent;
        i_back  = bck;
        i_clear = clr;
        step();
        i_dot   = 6'd0;
        i_enter = 1'b0;
        i_back  = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic transfer();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("xfer_valid", 8'(o_valid), 8'h0);
        check("xfer_data", 8'(o_data), 8'h0);
        check("xfer_cmd", 8'(o_cmd), 8'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        i_dot   = 6'd0;
        i_enter = 1'b0;
        i_back  = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b0;
        step();
        step();
        check("rst_valid", 8'(o_valid), 8'h0);
        check("rst_cmd", 8'(o_cmd), 8'h0);
        check("rst_data", 8'(o_data), 8'h0);
        check("rst_pattern", 8'(o_pattern), 8'h0);
        check("rst_drop", 8'(o_drop), 8'h0);
        reset_n = 1'b1;
        step();

        // Compose 01 then 05, commit with enter, hold off ready for 10 cycles.
        pulse(6'h01, 1'b0, 1'b0, 1'b0);
        check("c1_pattern", 8'(o_pattern), 8'h01);
        check("c1_valid", 8'(o_valid), 8'h0);
        pulse(6'h04, 1'b0, 1'b0, 1'b0);
        check("c2_pattern", 8'(o_pattern), 8'h05);
        pulse(6'h00, 1'b1, 1'b0, 1'b0);
        check("c3_valid", 8'(o_valid), 8'h1);
        check("c3_cmd", 8'(o_cmd), 8'h0);
        check("c3_data", 8'(o_data), 8'h05);
        check("c3_pattern", 8'(o_pattern), 8'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_valid", 8'(o_valid), 8'h1);
            check("hold_data", 8'(o_data), 8'h05);
        end
        transfer();
        check("c4_pattern", 8'(o_pattern), 8'h0);

        // Toggle a dot on and off, then backspace from IDLE.
        pulse(6'h02, 1'b0, 1'b0, 1'b0);
        check("t1_pattern", 8'(o_pattern), 8'h02);
        pulse(6'h02, 1'b0, 1'b0, 1'b0);
        check("t2_pattern", 8'(o_pattern), 8'h00);
        check("t2_valid", 8'(o_valid), 8'h0);
        pulse(6'h00, 1'b0, 1'b1, 1'b0);
        check("bk_valid", 8'(o_valid), 8'h1);
        check("bk_cmd", 8'(o_cmd), 8'h1);
        check("bk_data", 8'(o_data), 8'h0);
        transfer();

        // Auto-commit 8 cycles after the last dot pulse edge.
        pulse(6'h21, 1'b0, 1'b0, 1'b0);
        check("to_pattern", 8'(o_pattern), 8'h21);
        for (int k = 1; k < 8; k++) begin
            step();
            check("to_wait_valid", 8'(o_valid), 8'h0);
        end
        step();
        check("to_valid", 8'(o_valid), 8'h1);
        check("to_cmd", 8'(o_cmd), 8'h0);
        check("to_data", 8'(o_data), 8'h21);
        check("to_pattern0", 8'(o_pattern), 8'h0);
        transfer();

        // A dot at cycle 5 restarts the count.
        pulse(6'h21, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 5; k++) begin
            step();
        end
        pulse(6'h02, 1'b0, 1'b0, 1'b0);
        check("rs_pattern", 8'(o_pattern), 8'h23);
        for (int k = 1; k < 8; k++) begin
            step();
            check("rs_wait_valid", 8'(o_valid), 8'h0);
        end
        step();
        check("rs_valid", 8'(o_valid), 8'h1);
        check("rs_data", 8'(o_data), 8'h23);
        transfer();

        // Clear beats enter in the same cycle.
        pulse(6'h3F, 1'b0, 1'b0, 1'b0);
        check("pr_pattern", 8'(o_pattern), 8'h3F);
        pulse(6'h00, 1'b1, 1'b0, 1'b1);
        check("pr_valid", 8'(o_valid), 8'h1);
        check("pr_cmd", 8'(o_cmd), 8'h2);
        check("pr_data", 8'(o_data), 8'h0);
        check("pr_pattern0", 8'(o_pattern), 8'h0);
        transfer();
        step();
        check("pr_single", 8'(o_valid), 8'h0);

        // Events while busy are dropped, including in the transfer cycle.
        pulse(6'h0C, 1'b0, 1'b0, 1'b0);
        pulse(6'h00, 1'b1, 1'b0, 1'b0);
        check("dr_data", 8'(o_data), 8'h0C);
        check("dr_drop0", 8'(o_drop), 8'h0);
        pulse(6'h01, 1'b0, 1'b0, 1'b0);
        check("dr_drop_dot", 8'(o_drop), 8'h1);
        check("dr_data_dot", 8'(o_data), 8'h0C);
        check("dr_pat_dot", 8'(o_pattern), 8'h0);
        step();
        check("dr_drop_end1", 8'(o_drop), 8'h0);
        pulse(6'h00, 1'b1, 1'b0, 1'b0);
        check("dr_drop_ent", 8'(o_drop), 8'h1);
        check("dr_valid_ent", 8'(o_valid), 8'h1);
        check("dr_data_ent", 8'(o_data), 8'h0C);
        step();
        check("dr_drop_end2", 8'(o_drop), 8'h0);
        i_ready = 1'b1;
        pulse(6'h08, 1'b0, 1'b0, 1'b0);
        i_ready = 1'b0;
        check("dr_xfer_drop", 8'(o_drop), 8'h1);
        check("dr_xfer_valid", 8'(o_valid), 8'h0);
        check("dr_xfer_pat", 8'(o_pattern), 8'h0);
        step();
        check("dr_after_pat", 8'(o_pattern), 8'h0);
        check("dr_after_drop", 8'(o_drop), 8'h0);

        // Asynchronous reset in the middle of SEND.
        pulse(6'h00, 1'b0, 1'b1, 1'b0);
        pulse(6'h01, 1'b0, 1'b0, 1'b0);
        check("ar_pre_valid", 8'(o_valid), 8'h1);
        check("ar_pre_drop", 8'(o_drop), 8'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", 8'(o_valid), 8'h0);
        check("ar_cmd", 8'(o_cmd), 8'h0);
        check("ar_data", 8'(o_data), 8'h0);
        check("ar_pattern", 8'(o_pattern), 8'h0);
        check("ar_drop", 8'(o_drop), 8'h0);
        step();
        reset_n = 1'b1;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("ar_ready_idle", 8'(o_valid), 8'h0);
        pulse(6'h04, 1'b0, 1'b0, 1'b0);
        check("ar_idle_pattern", 8'(o_pattern), 8'h04);
        check("ar_idle_valid", 8'(o_valid), 8'h0);
        check("ar_idle_drop", 8'(o_drop), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
